rtx_range_marker: RTL and testbench

- Sits directly downstream of the incoming-ack user logic stage.
- Consumes that stage's mark_rtx / rtx_start / rtx_end decision and applies it to the flow's retransmit bitmap (rtx_wnd).
- Sets every bitmap bit whose sequence number falls in [rtx_start, rtx_end) relative to wnd_start, CHUNK bits per cycle, and reports how many bits were newly set.
- Result returns to the flow context writeback over a valid/ready handshake.

---
 rtl/rtx_range_marker.sv | 143 ++++++++++++++
 tb/tb_rtx_range_marker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rtx_range_marker.sv
// Applies a retransmit-range decision to a flow's rtx bitmap, CHUNK bits per
// cycle, and reports how many bits went from 0 to 1.
module rtx_range_marker #(
   parameter int SEQ_W     = 32,
   parameter int WIN_SIZE  = 128,
   parameter int CHUNK     = 16,
   parameter int FLOW_ID_W = 10,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [FLOW_ID_W-1:0] in_flow_id,
   input  logic                 in_mark_rtx,
   input  logic [SEQ_W-1:0]     in_rtx_start,
   input  logic [SEQ_W-1:0]     in_rtx_end,
   input  logic [SEQ_W-1:0]     in_wnd_start,
   input  logic [WIN_SIZE-1:0]  in_rtx_wnd,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [FLOW_ID_W-1:0] out_flow_id,
   output logic [WIN_SIZE-1:0]  out_rtx_wnd,
   output logic [CNT_W-1:0]     out_new_cnt
);

   localparam int WIN_LG   = $clog2(WIN_SIZE);
   localparam int CHUNK_LG = $clog2(CHUNK);
   localparam int KW       = WIN_LG - CHUNK_LG;

   typedef enum logic [1:0] {IDLE, MARK, OUT} state_e;

   state_e                state_q, state_d;
   logic [FLOW_ID_W-1:0]  flow_id_q, flow_id_d;
   logic [WIN_SIZE-1:0]   wnd_q, wnd_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [WIN_LG-1:0]     s_off_q, s_off_d;
   logic [CNT_W-1:0]      e_off_q, e_off_d;
   logic [KW-1:0]         k_q, k_d;
   logic [KW-1:0]         last_q, last_d;
   logic                  out_valid_q, out_valid_d;
   logic                  in_ready_q, in_ready_d;

   logic [SEQ_W-1:0]      s_full, e_full;
   logic [CNT_W-1:0]      e_clamp;
   logic [WIN_LG-1:0]     e_last;
   logic                  empty;
   logic [WIN_LG-1:0]     base, pos;
   logic [CHUNK-1:0]      chunk_old, chunk_new;
   logic [CNT_W-1:0]      add;

   always_comb begin
      state_d   = state_q;
      flow_id_d = flow_id_q;
      wnd_d     = wnd_q;
      cnt_d     = cnt_q;
      s_off_d   = s_off_q;
      e_off_d   = e_off_q;
      k_d       = k_q;
      last_d    = last_q;

      s_full  = in_rtx_start - in_wnd_start;
      e_full  = in_rtx_end - in_wnd_start;
      e_clamp = (e_full > SEQ_W'(WIN_SIZE)) ? CNT_W'(WIN_SIZE) : e_full[CNT_W-1:0];
      // Low bits of WIN_SIZE are zero, so this wraps to WIN_SIZE-1 when clamped.
      e_last  = e_clamp[WIN_LG-1:0] - WIN_LG'(1);
      empty   = !in_mark_rtx || (s_full >= SEQ_W'(e_clamp));

      base      = {k_q, {CHUNK_LG{1'b0}}};
      chunk_old = wnd_q[base +: CHUNK];
      chunk_new = chunk_old;
      add       = '0;
      pos       = '0;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         pos = base | WIN_LG'(i);
         if (pos >= s_off_q && {1'b0, pos} < e_off_q && !chunk_old[i]) begin
            chunk_new[i] = 1'b1;
            add          = add + CNT_W'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               flow_id_d = in_flow_id;
               wnd_d     = in_rtx_wnd;
               cnt_d     = '0;
               s_off_d   = s_full[WIN_LG-1:0];
               e_off_d   = e_clamp;
               k_d       = s_full[WIN_LG-1:CHUNK_LG];
               last_d    = e_last[WIN_LG-1:CHUNK_LG];
               state_d   = empty ? OUT : MARK;
            end
         end
         MARK: begin
            wnd_d[base +: CHUNK] = chunk_new;
            cnt_d = cnt_q + add;
            k_d   = k_q + KW'(1);
            if (k_q == last_q) state_d = OUT;
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = (state_d == OUT);
      in_ready_d  = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         flow_id_q   <= '0;
         wnd_q       <= '0;
         cnt_q       <= '0;
         s_off_q     <= '0;
         e_off_q     <= '0;
         k_q         <= '0;
         last_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         flow_id_q   <= flow_id_d;
         wnd_q       <= wnd_d;
         cnt_q       <= cnt_d;
         s_off_q     <= s_off_d;
         e_off_q     <= e_off_d;
         k_q         <= k_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_flow_id = flow_id_q;
   assign out_rtx_wnd = wnd_q;
   assign out_new_cnt = cnt_q;

endmodule

// File: tb/tb_rtx_range_marker.sv
// Directed bench for rtx_range_marker: latency, marking, clamp, wrap,
// backpressure and mid-request reset.
module tb_rtx_range_marker;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [9:0]   in_flow_id;
   logic         in_mark_rtx;
   logic [31:0]  in_rtx_start, in_rtx_end, in_wnd_start;
   logic [127:0] in_rtx_wnd;
   logic         out_valid;
   logic         out_ready;
   logic [9:0]   out_flow_id;
   logic [127:0] out_rtx_wnd;
   logic [7:0]   out_new_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rtx_range_marker #(
      .SEQ_W(32), .WIN_SIZE(128), .CHUNK(16), .FLOW_ID_W(10), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_flow_id(in_flow_id),
      .in_mark_rtx(in_mark_rtx), .in_rtx_start(in_rtx_start), .in_rtx_end(in_rtx_end),
      .in_wnd_start(in_wnd_start), .in_rtx_wnd(in_rtx_wnd),
      .out_valid(out_valid), .out_ready(out_ready), .out_flow_id(out_flow_id),
      .out_rtx_wnd(out_rtx_wnd), .out_new_cnt(out_new_cnt)
   );

   // Presents one request at a negedge; it is taken on the following posedge.
   task automatic accept(input logic [9:0] fid, input logic mark, input logic [31:0] ws,
                         input logic [31:0] s, input logic [31:0] e, input logic [127:0] wnd);
      @(negedge clk);
      in_valid = 1'b1; in_flow_id = fid; in_mark_rtx = mark;
      in_wnd_start = ws; in_rtx_start = s; in_rtx_end = e; in_rtx_wnd = wnd;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Counts negedges after the accept edge until out_valid; -1 on timeout.
   task automatic wait_out(output int lat);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      total++; if (out_rtx_wnd !== 128'h0 || out_new_cnt !== 8'd0 || out_flow_id !== 10'd0) begin
         bad++; $display("FAIL rst_outputs wnd=%h cnt=%0d fid=%0d exp all 0", out_rtx_wnd, out_new_cnt, out_flow_id);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_pass_through();
      int lat;
      accept(10'd7, 1'b0, 32'd1000, 32'd1000, 32'd1010, 128'h5);
      wait_out(lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL pass_latency got=%0d exp=1", lat); end
      total++; if (out_rtx_wnd !== 128'h5) begin bad++; $display("FAIL pass_wnd got=%h exp=5", out_rtx_wnd); end
      total++; if (out_new_cnt !== 8'd0) begin bad++; $display("FAIL pass_cnt got=%0d exp=0", out_new_cnt); end
      total++; if (out_flow_id !== 10'd7) begin bad++; $display("FAIL pass_fid got=%0d exp=7", out_flow_id); end
      release_out();
   endtask

   task automatic test_single_chunk();
      int lat;
      accept(10'd11, 1'b1, 32'd1000, 32'd1000, 32'd1005, 128'h0);
      wait_out(lat);
      total++; if (lat !== 2) begin bad++; $display("FAIL single_latency got=%0d exp=2", lat); end
      total++; if (out_rtx_wnd !== 128'h1F) begin bad++; $display("FAIL single_wnd got=%h exp=1f", out_rtx_wnd); end
      total++; if (out_new_cnt !== 8'd5) begin bad++; $display("FAIL single_cnt got=%0d exp=5", out_new_cnt); end
      release_out();
   endtask

   task automatic test_multi_chunk();
      int lat;
      accept(10'd12, 1'b1, 32'd1000, 32'd1000, 32'd1040, (128'h1 << 10) | (128'h1 << 20));
      wait_out(lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL multi_latency got=%0d exp=4", lat); end
      total++; if (out_rtx_wnd !== 128'hFF_FFFF_FFFF) begin bad++; $display("FAIL multi_wnd got=%h exp=ffffffffff", out_rtx_wnd); end
      total++; if (out_new_cnt !== 8'd38) begin bad++; $display("FAIL multi_cnt got=%0d exp=38", out_new_cnt); end
      release_out();
   endtask

   task automatic test_chunk_boundary();
      int lat;
      accept(10'd13, 1'b1, 32'd0, 32'd14, 32'd18, 128'h1 << 15);
      wait_out(lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL bound_latency got=%0d exp=3", lat); end
      total++; if (out_rtx_wnd !== 128'h3C000) begin bad++; $display("FAIL bound_wnd got=%h exp=3c000", out_rtx_wnd); end
      total++; if (out_new_cnt !== 8'd3) begin bad++; $display("FAIL bound_cnt got=%0d exp=3", out_new_cnt); end
      release_out();
   endtask

   task automatic test_clamp_empty();
      int lat;
      accept(10'd14, 1'b1, 32'd1000, 32'd1100, 32'd1300, 128'h0);
      wait_out(lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL clamp_latency got=%0d exp=3", lat); end
      total++; if (out_rtx_wnd !== {28'hFFF_FFFF, 100'h0}) begin bad++; $display("FAIL clamp_wnd got=%h", out_rtx_wnd); end
      total++; if (out_new_cnt !== 8'd28) begin bad++; $display("FAIL clamp_cnt got=%0d exp=28", out_new_cnt); end
      release_out();
      accept(10'd15, 1'b1, 32'd1000, 32'd1200, 32'd1300, 128'hABC);
      wait_out(lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL empty_latency got=%0d exp=1", lat); end
      total++; if (out_rtx_wnd !== 128'hABC) begin bad++; $display("FAIL empty_wnd got=%h exp=abc", out_rtx_wnd); end
      total++; if (out_new_cnt !== 8'd0) begin bad++; $display("FAIL empty_cnt got=%0d exp=0", out_new_cnt); end
      release_out();
   endtask

   task automatic test_wrap();
      int lat;
      accept(10'd16, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0000_0010, 128'h0);
      wait_out(lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL wrap_latency got=%0d exp=3", lat); end
      total++; if (out_rtx_wnd !== 128'hFFFF_FFFF) begin bad++; $display("FAIL wrap_wnd got=%h exp=ffffffff", out_rtx_wnd); end
      total++; if (out_new_cnt !== 8'd32) begin bad++; $display("FAIL wrap_cnt got=%0d exp=32", out_new_cnt); end
      release_out();
   endtask

   task automatic test_backpressure();
      int lat;
      accept(10'd17, 1'b1, 32'd500, 32'd502, 32'd504, 128'h0);
      wait_out(lat);
      total++; if (lat !== 2) begin bad++; $display("FAIL bp_latency got=%0d exp=2", lat); end
      // A competing request while busy must be ignored.
      in_valid = 1'b1; in_flow_id = 10'd99; in_mark_rtx = 1'b1;
      in_wnd_start = 32'd0; in_rtx_start = 32'd0; in_rtx_end = 32'd128; in_rtx_wnd = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rtx_wnd !== 128'hC ||
             out_new_cnt !== 8'd2 || out_flow_id !== 10'd17) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d valid=%b ready=%b wnd=%h cnt=%0d fid=%0d exp 1 0 c 2 17",
                     c, out_valid, in_ready, out_rtx_wnd, out_new_cnt, out_flow_id);
         end
      end
      in_valid = 1'b0;
      release_out();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL bp_idle valid=%b ready=%b exp 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_in_mark();
      bit seen;
      accept(10'd20, 1'b1, 32'd1000, 32'd1000, 32'd1040, 128'h0);
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mark_busy ready=%b exp=0", in_ready); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL rstmark_state valid=%b ready=%b exp 0 1", out_valid, in_ready);
      end
      total++; if (out_rtx_wnd !== 128'h0 || out_new_cnt !== 8'd0 || out_flow_id !== 10'd0) begin
         bad++; $display("FAIL rstmark_outputs wnd=%h cnt=%0d fid=%0d exp all 0", out_rtx_wnd, out_new_cnt, out_flow_id);
      end
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmark_no_result got=%b exp=0", seen); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_flow_id = '0; in_mark_rtx = 1'b0; in_rtx_start = '0; in_rtx_end = '0;
      in_wnd_start = '0; in_rtx_wnd = '0;
      test_reset();
      test_pass_through();
      test_single_chunk();
      test_multi_chunk();
      test_chunk_boundary();
      test_clamp_empty();
      test_wrap();
      test_backpressure();
      test_reset_in_mark();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
